rr_encoder: RTL and testbench

Round-robin request encoder, the inverse of the register-file write decoder: collects up to 16 one-hot/multi-hot source requests and returns them one at a time as a 4-bit register index. Requests are sticky until granted. The grant is presented through a registered valid/ready output with fair round-robin ordering. Sits between the multiplier's completion/request lines and the register-file write-back path that consumes a 4-bit index.

---
 rtl/rr_encoder.sv | 73 +++++++
 tb/tb_rr_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder.sv
// rtl/rr_encoder.sv - round-robin encoder from 16 sticky requests to one registered 4-bit grant
module rr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] reqSet,
    input  logic        srcReady,
    output logic        srcValid,
    output logic [3:0]  srcReg,
    output logic [15:0] srcOneHot,
    output logic [4:0]  pendCount
);

    logic [15:0] pending;
    logic [3:0]  ptr;
    logic [3:0]  sel;
    logic        accept;
    logic        load;
    logic [15:0] sel_mask;
    logic [15:0] clr_mask;

    // Search starts at ptr and wraps; the 4-bit add provides the 15 -> 0 wrap.
    always_comb begin
        logic [3:0] idx;
        logic       found;
        sel   = 4'd0;
        idx   = 4'd0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + i[3:0];
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, pending[i]};
        end
        pendCount = cnt;
    end

    assign accept   = srcValid & srcReady;
    assign load     = (!srcValid | accept) & (pending != 16'h0000);
    assign sel_mask = 16'h0001 << sel;
    assign clr_mask = load ? sel_mask : 16'h0000;

    // A new request on the bit being granted survives the clear: set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= 16'h0000;
            ptr       <= 4'd0;
            srcValid  <= 1'b0;
            srcReg    <= 4'd0;
            srcOneHot <= 16'h0000;
        end else begin
            pending <= (pending & ~clr_mask) | reqSet;
            if (load) begin
                srcValid  <= 1'b1;
                srcReg    <= sel;
                srcOneHot <= sel_mask;
                ptr       <= sel + 4'd1;
            end else if (accept) begin
                srcValid  <= 1'b0;
                srcOneHot <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_rr_encoder.sv
// tb/tb_rr_encoder.sv - directed and randomized checks of rr_encoder against a reference model
module tb_rr_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] reqSet;
    logic        srcReady;
    logic        srcValid;
    logic [3:0]  srcReg;
    logic [15:0] srcOneHot;
    logic [4:0]  pendCount;

    int checks = 0;
    int passed = 0;

    // Reference model state: requests as a set of waiting source numbers.
    bit          m_wait [16];
    int          m_ptr;
    bit          m_valid;
    int          m_reg;

    rr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqSet    (reqSet),
        .srcReady  (srcReady),
        .srcValid  (srcValid),
        .srcReg    (srcReg),
        .srcOneHot (srcOneHot),
        .pendCount (pendCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic [15:0] req, input bit rdy, input bit rstn);
        bit taken;
        int pick;
        if (!rstn) begin
            foreach (m_wait[i]) m_wait[i] = 0;
            m_ptr   = 0;
            m_valid = 0;
            m_reg   = 0;
            return;
        end
        taken = m_valid && rdy;
        pick  = -1;
        if (!m_valid || taken) begin
            for (int d = 0; d < 16; d++) begin
                if (pick < 0 && m_wait[(m_ptr + d) % 16]) pick = (m_ptr + d) % 16;
            end
        end
        if (pick >= 0) begin
            m_wait[pick] = 0;
            m_valid      = 1;
            m_reg        = pick;
            m_ptr        = (pick + 1) % 16;
        end else if (taken) begin
            m_valid = 0;
        end
        for (int i = 0; i < 16; i++) if (req[i]) m_wait[i] = 1;
    endtask

    function automatic logic [25:0] model_out();
        int cnt;
        logic [15:0] oh;
        cnt = 0;
        foreach (m_wait[i]) cnt += m_wait[i];
        oh = m_valid ? (16'h0001 << m_reg) : 16'h0000;
        return {m_valid, 4'(m_reg), oh, 5'(cnt)};
    endfunction

    task automatic cyc(input logic [15:0] req, input bit rdy, input bit rstn);
        reqSet   = req;
        srcReady = rdy;
        rst_n    = rstn;
        @(posedge clk);
        model_step(req, rdy, rstn);
        #1;
    endtask

    // Packed view used by the directed tests: {valid, reg, onehot, count}.
    function automatic logic [25:0] exp_out(input bit v, input int r, input int cnt);
        return {v, 4'(r), (v ? (16'h0001 << r) : 16'h0000), 5'(cnt)};
    endfunction

    task automatic test_reset();
        logic [25:0] got;
        for (int i = 0; i < 3; i++) begin
            cyc(16'hFFFF, 1, 0);
            got = {srcValid, srcReg, srcOneHot, pendCount};
            checks++;
            if (got !== 26'd0) $display("FAIL reset_hold cycle %0d got=%h want=%h", i, got, 26'd0);
            else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            cyc(16'h0000, 0, 1);
            got = {srcValid, srcReg, srcOneHot, pendCount};
            checks++;
            if (got !== 26'd0) $display("FAIL reset_release cycle %0d got=%h want=%h", i, got, 26'd0);
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [25:0] got;
        logic [25:0] want [3];
        want[0] = exp_out(0, 0, 1);
        want[1] = exp_out(1, 5, 0);
        want[2] = {1'b0, 4'd5, 16'h0000, 5'd0};
        cyc(16'h0020, 1, 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc(16'h0000, 1, 1);
            got = {srcValid, srcReg, srcOneHot, pendCount};
            checks++;
            if (got !== want[i]) $display("FAIL single step %0d got=%h want=%h", i, got, want[i]);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        logic [25:0] got;
        int order [5] = '{0, 8, 15, 1, 2};
        int k;
        cyc(16'h0000, 1, 0);
        cyc(16'h8101, 1, 1);
        k = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(16'h0000, 1, 1);
            got = {srcValid, srcReg, srcOneHot, pendCount};
            checks++;
            if (got !== exp_out(1, order[k], 2 - i)) $display("FAIL rr_grant %0d got=%h want=%h", k, got, exp_out(1, order[k], 2 - i));
            else passed++;
            k++;
        end
        cyc(16'h0006, 1, 1);
        checks++;
        if (srcValid !== 1'b0 || pendCount !== 5'd2) $display("FAIL rr_gap got valid=%b count=%0d want valid=0 count=2", srcValid, pendCount);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            cyc(16'h0000, 1, 1);
            got = {srcValid, srcReg, srcOneHot, pendCount};
            checks++;
            if (got !== exp_out(1, order[k], 1 - i)) $display("FAIL rr_wrap_grant %0d got=%h want=%h", k, got, exp_out(1, order[k], 1 - i));
            else passed++;
            k++;
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] got;
        cyc(16'h0000, 1, 0);
        cyc(16'h0008, 0, 1);
        cyc(16'h0410, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(16'h0000, 0, 1);
            got = {srcValid, srcReg, srcOneHot, pendCount};
            checks++;
            if (got !== exp_out(1, 3, 2)) $display("FAIL bp_hold cycle %0d got=%h want=%h", i, got, exp_out(1, 3, 2));
            else passed++;
        end
        cyc(16'h0000, 1, 1);
        got = {srcValid, srcReg, srcOneHot, pendCount};
        checks++;
        if (got !== exp_out(1, 4, 1)) $display("FAIL bp_release_first got=%h want=%h", got, exp_out(1, 4, 1));
        else passed++;
        cyc(16'h0000, 1, 1);
        got = {srcValid, srcReg, srcOneHot, pendCount};
        checks++;
        if (got !== exp_out(1, 10, 0)) $display("FAIL bp_release_second got=%h want=%h", got, exp_out(1, 10, 0));
        else passed++;
        cyc(16'h0000, 1, 1);
    endtask

    task automatic test_collision();
        logic [25:0] got;
        cyc(16'h0000, 1, 0);
        cyc(16'h0004, 1, 1);
        cyc(16'h0004, 1, 1);
        got = {srcValid, srcReg, srcOneHot, pendCount};
        checks++;
        if (got !== exp_out(1, 2, 1)) $display("FAIL collision_first got=%h want=%h", got, exp_out(1, 2, 1));
        else passed++;
        cyc(16'h0000, 1, 1);
        got = {srcValid, srcReg, srcOneHot, pendCount};
        checks++;
        if (got !== exp_out(1, 2, 0)) $display("FAIL collision_second got=%h want=%h", got, exp_out(1, 2, 0));
        else passed++;
        cyc(16'h0000, 1, 1);
        checks++;
        if (srcValid !== 1'b0) $display("FAIL collision_drain got valid=%b want 0", srcValid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [25:0] got;
        cyc(16'h0000, 1, 0);
        cyc(16'h0010, 0, 1);
        cyc(16'h00F0, 0, 1);
        got = {srcValid, srcReg, srcOneHot, pendCount};
        checks++;
        if (got !== exp_out(1, 4, 4)) $display("FAIL midreset_setup got=%h want=%h", got, exp_out(1, 4, 4));
        else passed++;
        cyc(16'hFFFF, 1, 0);
        got = {srcValid, srcReg, srcOneHot, pendCount};
        checks++;
        if (got !== 26'd0) $display("FAIL midreset_clear got=%h want=%h", got, 26'd0);
        else passed++;
        cyc(16'h8001, 1, 1);
        cyc(16'h0000, 1, 1);
        got = {srcValid, srcReg, srcOneHot, pendCount};
        checks++;
        if (got !== exp_out(1, 0, 1)) $display("FAIL midreset_ptr got=%h want=%h", got, exp_out(1, 0, 1));
        else passed++;
    endtask

    task automatic test_random();
        logic [25:0] got;
        logic [25:0] want;
        logic [15:0] req;
        bit          rdy;
        bit          rstn;
        int          errs;
        errs = 0;
        cyc(16'h0000, 1, 0);
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: req = 16'h0000;
                1: req = 16'(1 << $urandom_range(0, 15));
                2: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: req = 16'($urandom);
            endcase
            rdy  = ($urandom_range(0, 3) != 0);
            rstn = ($urandom_range(0, 63) != 0);
            cyc(req, rdy, rstn);
            got  = {srcValid, srcReg, srcOneHot, pendCount};
            want = model_out();
            checks++;
            if (got !== want) begin
                if (errs < 10) $display("FAIL random cycle %0d got=%h want=%h", i, got, want);
                errs++;
            end else begin
                passed++;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        reqSet   = 16'h0000;
        srcReady = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
